// File: rtl/mmio_bridge_pkg.sv
// Shared types and constants for the MMIO bus bridge.
//   state_t     : bridge FSM states (IDLE / ACCESS / RESP)
//   MMIO_ADDR_W : word-address width toward the MMIO controller
//   MMIO_DATA_W : data width
//   REGION_MSB  : lowest address bit that selects the 8 MiB I/O region
package mmio_bridge_pkg;

  localparam int MMIO_ADDR_W = 21;
  localparam int MMIO_DATA_W = 32;
  localparam int REGION_MSB  = 23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mmio_bridge_decode.sv
// Combinational address decode for the MMIO bus bridge.
// Ports:
//   i_addr       : CPU byte address
//   o_hit        : address inside the region and word aligned
//   o_miss       : address outside the region selected by BASE_ADDR[31:23]
//   o_misaligned : address bits [1:0] non-zero
module mmio_bridge_decode
  import mmio_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hC000_0000
) (
  input  logic [31:0] i_addr,
  output logic        o_hit,
  output logic        o_miss,
  output logic        o_misaligned
);

  // Only the bits at and above REGION_MSB select the region.
  localparam logic [31:0] REGION_MASK = ~((32'd1 << REGION_MSB) - 32'd1);

  always_comb begin
    o_miss       = ((i_addr ^ BASE_ADDR) & REGION_MASK) != 32'd0;
    o_misaligned = i_addr[1:0] != 2'b00;
    o_hit        = !o_miss && !o_misaligned;
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// CPU request/response to MMIO strobe bridge.
// Ports:
//   clk, reset (async, active low)
//   cpu_req_*  : valid/ready request channel (we, addr, wdata)
//   cpu_rsp_*  : valid/ready response channel (rdata, err)
//   mmio_*     : registered cs/wr/rd strobes, word address and write data;
//                mmio_rd_data returned by the controller during the strobe
// Build option MMIO_BRIDGE_WPOST_EN: hit writes are posted (no response).
//
// state  | meaning
// IDLE   | ready for a new request
// ACCESS | one-cycle mmio strobe in flight
// RESP   | response held until cpu_rsp_ready
module mmio_bus_bridge
  import mmio_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hC000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic                   cpu_req_we,
  input  logic [31:0]            cpu_req_addr,
  input  logic [31:0]            cpu_req_wdata,
  output logic                   cpu_rsp_valid,
  input  logic                   cpu_rsp_ready,
  output logic [MMIO_DATA_W-1:0] cpu_rsp_rdata,
  output logic                   cpu_rsp_err,
  output logic                   mmio_cs,
  output logic                   mmio_wr,
  output logic                   mmio_rd,
  output logic [MMIO_ADDR_W-1:0] mmio_addr,
  output logic [MMIO_DATA_W-1:0] mmio_wr_data,
  input  logic [MMIO_DATA_W-1:0] mmio_rd_data
);

  state_t                 r_state, w_state_nxt;
  logic                   r_rst_done;
  logic                   r_we, w_we_nxt;
  logic                   r_cs, w_cs_nxt;
  logic                   r_wr, w_wr_nxt;
  logic                   r_rd, w_rd_nxt;
  logic                   r_rsp_valid, w_rsp_valid_nxt;
  logic                   r_rsp_err, w_rsp_err_nxt;
  logic [MMIO_DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [MMIO_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [MMIO_DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic                   w_hit, w_miss, w_misaligned;
  logic                   w_req_ready;

  mmio_bridge_decode #(.BASE_ADDR(BASE_ADDR)) u_decode (
    .i_addr       (cpu_req_addr),
    .o_hit        (w_hit),
    .o_miss       (w_miss),
    .o_misaligned (w_misaligned)
  );

  // r_rst_done keeps ready low until the first edge after reset release.
  assign w_req_ready   = r_rst_done && (r_state == IDLE);
  assign cpu_req_ready = w_req_ready;
  assign cpu_rsp_valid = r_rsp_valid;
  assign cpu_rsp_rdata = r_rsp_rdata;
  assign cpu_rsp_err   = r_rsp_err;
  assign mmio_cs       = r_cs;
  assign mmio_wr       = r_wr;
  assign mmio_rd       = r_rd;
  assign mmio_addr     = r_addr;
  assign mmio_wr_data  = r_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rst_done  <= 1'b0;
      r_we        <= 1'b0;
      r_cs        <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rst_done  <= 1'b1;
      r_we        <= w_we_nxt;
      r_cs        <= w_cs_nxt;
      r_wr        <= w_wr_nxt;
      r_rd        <= w_rd_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
    end
  end

  // Strobes and rsp_valid are computed one state ahead so they leave the
  // flops aligned with the state they belong to.
  always_comb begin
    w_state_nxt     = r_state;
    w_we_nxt        = r_we;
    w_cs_nxt        = 1'b0;
    w_wr_nxt        = 1'b0;
    w_rd_nxt        = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    case (r_state)
      IDLE: begin
        if (cpu_req_valid && w_req_ready) begin
          if (w_hit) begin
            w_addr_nxt  = cpu_req_addr[REGION_MSB-1:2];
            w_wdata_nxt = cpu_req_wdata;
            w_we_nxt    = cpu_req_we;
            w_cs_nxt    = 1'b1;
            w_wr_nxt    = cpu_req_we;
            w_rd_nxt    = !cpu_req_we;
            w_state_nxt = ACCESS;
          end else begin
            // mmio_addr/wr_data are left untouched so no out-of-region
            // bits ever reach the controller.
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = w_miss || w_misaligned;
            w_rsp_rdata_nxt = '0;
            w_state_nxt     = RESP;
          end
        end
      end
      ACCESS: begin
        if (r_we) begin
`ifdef MMIO_BRIDGE_WPOST_EN
          w_state_nxt = IDLE;
`else
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = '0;
          w_state_nxt     = RESP;
`endif
        end else begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = mmio_rd_data;
          w_state_nxt     = RESP;
        end
      end
      RESP: begin
        if (cpu_rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_bus_bridge.sv
module tb_mmio_bus_bridge;

  localparam logic [31:0] BASE = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_req_we = 1'b0;
  logic [31:0] cpu_req_addr = '0;
  logic [31:0] cpu_req_wdata = '0;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ready = 1'b0;
  logic [31:0] cpu_rsp_rdata;
  logic        cpu_rsp_err;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data = '0;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the controller-side registers should currently show.
  logic [20:0] m_maddr = '0;
  logic [31:0] m_wdata = '0;

  mmio_bus_bridge #(.BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_ready (cpu_rsp_ready),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .cpu_rsp_err   (cpu_rsp_err),
    .mmio_cs       (mmio_cs),
    .mmio_wr       (mmio_wr),
    .mmio_rd       (mmio_rd),
    .mmio_addr     (mmio_addr),
    .mmio_wr_data  (mmio_wr_data),
    .mmio_rd_data  (mmio_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction starting at a negedge with the bridge idle.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rdv, input int hold,
                     input logic e_strobe, input logic e_err,
                     input logic [31:0] e_rdata, input logic [20:0] e_maddr);
    if (e_strobe) m_wdata = wd;
    chk({tag, ".req_ready_idle"}, cpu_req_ready, 1);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr;
    cpu_req_wdata = wd; mmio_rd_data = rdv; cpu_rsp_ready = 1'b0;
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_req_addr = $urandom; cpu_req_wdata = $urandom;
    cpu_req_we = 1'($urandom_range(0, 1));
    chk({tag, ".cs"}, mmio_cs, e_strobe);
    chk({tag, ".maddr"}, mmio_addr, e_maddr);
    chk({tag, ".wdata"}, mmio_wr_data, m_wdata);
    if (e_strobe) begin
      chk({tag, ".wr"}, mmio_wr, we);
      chk({tag, ".rd"}, mmio_rd, !we);
      chk({tag, ".rsp_valid_access"}, cpu_rsp_valid, 0);
      @(negedge clk);
      mmio_rd_data = $urandom;
      chk({tag, ".strobes_after"}, {mmio_cs, mmio_wr, mmio_rd}, 0);
`ifdef MMIO_BRIDGE_WPOST_EN
      if (we) begin
        chk({tag, ".posted_no_rsp"}, cpu_rsp_valid, 0);
        chk({tag, ".posted_ready"}, cpu_req_ready, 1);
        return;
      end
`endif
    end
    chk({tag, ".rsp_valid"}, cpu_rsp_valid, 1);
    chk({tag, ".rdata"}, cpu_rsp_rdata, e_rdata);
    chk({tag, ".err"}, cpu_rsp_err, e_err);
    chk({tag, ".req_ready_resp"}, cpu_req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      mmio_rd_data = $urandom;
      chk({tag, ".hold_valid"}, cpu_rsp_valid, 1);
      chk({tag, ".hold_rdata"}, cpu_rsp_rdata, e_rdata);
      chk({tag, ".hold_err"}, cpu_rsp_err, e_err);
      chk({tag, ".hold_ready"}, cpu_req_ready, 0);
      chk({tag, ".hold_cs"}, mmio_cs, 0);
    end
    cpu_rsp_ready = 1'b1;
    @(negedge clk);
    cpu_rsp_ready = 1'b0;
    chk({tag, ".rsp_done"}, cpu_rsp_valid, 0);
    chk({tag, ".back_idle"}, cpu_req_ready, 1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdval;
    int          hold;
    logic        e_strobe;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [20:0] e_maddr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [8:0] pat_cs, pat_rv;

    tbl[0] = '{1'b1, 32'hC000_0044, 32'hDEAD_BEEF, 32'h0,         0, 1'b1, 1'b0, 32'h0,         21'h11};
    tbl[1] = '{1'b0, 32'hC000_07E0, 32'h0,         32'h1234_5678, 0, 1'b1, 1'b0, 32'h1234_5678, 21'h1F8};
    tbl[2] = '{1'b0, 32'h8000_0000, 32'h5555_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'h0,         21'h1F8};
    tbl[3] = '{1'b0, 32'hC000_0002, 32'h6666_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'h0,         21'h1F8};
    tbl[4] = '{1'b0, 32'hC000_0100, 32'h0,         32'hA5A5_5A5A, 5, 1'b1, 1'b0, 32'hA5A5_5A5A, 21'h40};
    tbl[5] = '{1'b1, 32'hC07F_FFFC, 32'h0000_0001, 32'h0,         1, 1'b1, 1'b0, 32'h0,         21'h1F_FFFF};
    tbl[6] = '{1'b1, 32'hC080_0000, 32'h7777_7777, 32'h0,         0, 1'b0, 1'b1, 32'h0,         21'h1F_FFFF};
    tbl[7] = '{1'b1, 32'hC000_0001, 32'h8888_8888, 32'h0,         2, 1'b0, 1'b1, 32'h0,         21'h1F_FFFF};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.req_ready", cpu_req_ready, 0);
    chk("rst.strobes", {mmio_cs, mmio_wr, mmio_rd}, 0);
    chk("rst.maddr", mmio_addr, 0);
    chk("rst.wdata", mmio_wr_data, 0);
    chk("rst.rsp", {cpu_rsp_valid, cpu_rsp_err}, 0);
    chk("rst.rdata", cpu_rsp_rdata, 0);
    reset = 1'b1;
    #1;
    chk("rst.ready_before_edge", cpu_req_ready, 0);
    @(negedge clk);
    chk("rst.ready_after_edge", cpu_req_ready, 1);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdval,
          tbl[i].hold, tbl[i].e_strobe, tbl[i].e_err, tbl[i].e_rdata, tbl[i].e_maddr);
      m_maddr = tbl[i].e_maddr;
    end

    // Throughput: continuous hit reads with rsp_ready held high.
    cpu_rsp_ready = 1'b1;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'hC000_0010; cpu_req_wdata = 32'h0;
    mmio_rd_data = 32'h0BAD_F00D;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      pat_cs[8-c] = mmio_cs;
      pat_rv[8-c] = cpu_rsp_valid;
    end
    chk("tput.cs_pattern", 32'(pat_cs), 32'(9'b100_100_100));
    chk("tput.valid_pattern", 32'(pat_rv), 32'(9'b010_010_010));
    cpu_req_valid = 1'b0;
    @(negedge clk);
    cpu_rsp_ready = 1'b0;
    @(negedge clk);
    chk("tput.rdata", cpu_rsp_rdata, 32'h0BAD_F00D);
    m_maddr = 21'h4; m_wdata = 32'h0;

    // Reset during ACCESS.
    chk("rstacc.ready", cpu_req_ready, 1);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'hC000_0020;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    chk("rstacc.cs_on", mmio_cs, 1);
    reset = 1'b0;
    #1;
    chk("rstacc.cs_drop", {mmio_cs, mmio_rd}, 0);
    chk("rstacc.no_rsp", cpu_rsp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstacc.no_rsp_after", cpu_rsp_valid, 0);
    end
    m_maddr = '0; m_wdata = '0;
    txn("rstacc.next", 1'b0, 32'hC000_0030, 32'h0, 32'hCAFE_0001, 0, 1'b1, 1'b0, 32'hCAFE_0001, 21'hC);
    m_maddr = 21'hC;

    // Reset during RESP.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h1000_0000;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    chk("rstresp.valid_on", cpu_rsp_valid, 1);
    reset = 1'b0;
    #1;
    chk("rstresp.valid_drop", cpu_rsp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstresp.idle", cpu_req_ready, 1);
    m_maddr = '0; m_wdata = '0;

`ifdef MMIO_BRIDGE_WPOST_EN
    // Back-to-back posted writes.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 32'hC000_0000; cpu_req_wdata = 32'h1111_1111;
    @(negedge clk);
    chk("post.cs1", {mmio_cs, mmio_wr}, 2'b11);
    chk("post.addr1", mmio_addr, 0);
    chk("post.norsp1", cpu_rsp_valid, 0);
    cpu_req_addr = 32'hC000_0004; cpu_req_wdata = 32'h2222_2222;
    @(negedge clk);
    chk("post.gap", mmio_cs, 0);
    chk("post.norsp2", cpu_rsp_valid, 0);
    chk("post.ready", cpu_req_ready, 1);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    chk("post.cs2", {mmio_cs, mmio_wr}, 2'b11);
    chk("post.addr2", mmio_addr, 1);
    chk("post.wdata2", mmio_wr_data, 32'h2222_2222);
    @(negedge clk);
    chk("post.norsp3", cpu_rsp_valid, 0);
    m_maddr = 21'h1; m_wdata = 32'h2222_2222;
`endif

    // Randomized transactions against the reference rules.
    for (int t = 0; t < 40; t++) begin
      logic        we, hit, e_err;
      logic [31:0] a, wd, rdv, e_rdata;
      logic [20:0] e_maddr;
      int          sel;
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      a   = $urandom;
      wd  = $urandom;
      rdv = $urandom;
      if (sel <= 1) a = (a % 32'h0080_0000) / 4 * 4 + BASE;
      else if (sel == 2) a = (a % 32'h0080_0000) / 4 * 4 + BASE + 32'($urandom_range(1, 3));
      hit     = ((a / 32'h0080_0000) == (BASE / 32'h0080_0000)) && (a % 4 == 0);
      e_err   = !hit;
      e_rdata = (hit && !we) ? rdv : 32'h0;
      e_maddr = hit ? 21'((a % 32'h0080_0000) / 4) : m_maddr;
      txn($sformatf("rnd%0d", t), we, a, wd, rdv, $urandom_range(0, 3),
          hit, e_err, e_rdata, e_maddr);
      m_maddr = e_maddr;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_bus_bridge.md
MMIO_BUS_BRIDGE -- requirements
Module: mmio_bus_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hC000_0000, meaning the I/O region base; only bits [31:23] are significant, giving an 8 MiB region.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-003 SHALL have port reset, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port cpu_req_valid, input, 1, meaning the CPU request is present.
REQ-005 SHALL have port cpu_req_ready, output, 1, meaning the bridge accepts a request this cycle.
REQ-006 SHALL have port cpu_req_we, input, 1, where 1 means write and 0 means read.
REQ-007 SHALL have port cpu_req_addr, input, 32, the byte address.
REQ-008 SHALL have port cpu_req_wdata, input, 32, the write data.
REQ-009 SHALL have port cpu_rsp_valid, output, 1, meaning the response is present.
REQ-010 SHALL have port cpu_rsp_ready, input, 1, meaning the CPU accepts the response.
REQ-011 SHALL have port cpu_rsp_rdata, output, 32, the read data.
REQ-012 SHALL have port cpu_rsp_err, output, 1, meaning a decode or alignment error.
REQ-013 SHALL have outputs mmio_cs (1), mmio_wr (1), mmio_rd (1), mmio_addr (21, word address) and mmio_wr_data (32), all toward the MMIO controller.
REQ-014 SHALL have port mmio_rd_data, input, 32, the read data from the MMIO controller.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, ACCESS and RESP.
REQ-016 cpu_req_ready SHALL be 1 only in IDLE; a request is accepted when cpu_req_valid and cpu_req_ready are both 1 at the clock edge.
REQ-017 A hit SHALL be defined as cpu_req_addr[31:23]==BASE_ADDR[31:23] and cpu_req_addr[1:0]==2'b00.
REQ-018 On an accepted hit, the bridge SHALL register mmio_addr=cpu_req_addr[22:2] and mmio_wr_data=cpu_req_wdata, then go to ACCESS.
REQ-019 In ACCESS, mmio_cs SHALL be 1 for exactly one cycle, together with mmio_wr=we or mmio_rd=!we.
REQ-020 All strobes SHALL be registered outputs and SHALL be 0 in every other state.
REQ-021 On a read, mmio_rd_data SHALL be sampled at the edge ending ACCESS into cpu_rsp_rdata, with cpu_rsp_err=0, and the FSM SHALL go to RESP.
REQ-022 On a non-posted write, the FSM SHALL go to RESP with cpu_rsp_rdata=0 and cpu_rsp_err=0.
REQ-023 On an accepted miss or misalignment, no bus strobe SHALL be issued; the FSM SHALL go directly to RESP with cpu_rsp_err=1 and cpu_rsp_rdata=0.
REQ-024 In RESP, cpu_rsp_valid SHALL be 1, with rdata and err held stable until cpu_rsp_ready=1; the FSM SHALL then return to IDLE.
REQ-025 Latency SHALL be: a hit is accept→strobe in 1 cycle and strobe→rsp_valid in 1 cycle; an error is accept→rsp_valid in 1 cycle.
REQ-026 Minimum throughput SHALL be one hit transaction per 3 cycles, with cpu_rsp_ready held at 1.
REQ-027 mmio_addr and mmio_wr_data SHALL hold their last values outside ACCESS.
REQ-028 Address bits outside the region SHALL never alias into mmio_addr on an error.

Reset
REQ-029 While reset=0, the FSM SHALL be IDLE, all mmio_* outputs 0, cpu_rsp_valid=0, cpu_rsp_rdata=0 and cpu_rsp_err=0.
REQ-030 cpu_req_ready SHALL be 0 while reset=0 and 1 from the first edge after deassertion.
REQ-031 Reset asserted in ACCESS or RESP SHALL drop the strobes and rsp_valid immediately, abandon the transaction and produce no response.

Configuration
REQ-032 Macro MMIO_BRIDGE_WPOST_EN defined: hit writes SHALL be posted, going ACCESS→IDLE with no response, so the write completes at acceptance.
REQ-033 With the macro defined, a write immediately following in IDLE SHALL be accepted the cycle after the strobe.
REQ-034 With the macro defined, reads and error responses SHALL be unchanged; error writes SHALL still produce an error response.
REQ-035 Macro undefined: every accepted request SHALL produce exactly one response.

Structure
REQ-036 Package mmio_bridge_pkg SHALL hold the state enum (IDLE/ACCESS/RESP) and the constants MMIO_ADDR_W=21, MMIO_DATA_W=32 and REGION_MSB=23.
REQ-037 Sub-module mmio_bridge_decode SHALL be combinational and produce hit, miss and misaligned from addr and BASE_ADDR; the FSM and registers SHALL stay in mmio_bus_bridge.

Verification
REQ-038 Write 0xC000_0044 with data 0xDEAD_BEEF → a single-cycle strobe with mmio_cs=1, mmio_wr=1, mmio_addr=21'h11, mmio_wr_data=0xDEAD_BEEF; then rsp_valid, err=0 (macro undefined).
REQ-039 Read 0xC000_07E0 with mmio_rd_data=0x1234_5678 during the strobe → mmio_rd=1, mmio_addr=21'h1F8; rsp_rdata=0x1234_5678 one cycle later.
REQ-040 Read 0x8000_0000, then 0xC000_0002 → no mmio_cs either time; each gives rsp_valid with err=1 and rdata=0, one cycle after acceptance.
REQ-041 cpu_rsp_ready held 0 for 5 cycles → rsp_valid and rdata stable and req_ready=0 throughout; return to IDLE the cycle after ready=1.
REQ-042 reset pulled low during ACCESS → mmio_cs drops immediately and no rsp_valid follows; the next request proceeds normally.
REQ-043 With MMIO_BRIDGE_WPOST_EN, back-to-back writes to 0xC000_0000 and 0xC000_0004 → two strobes 2 cycles apart and no rsp_valid.
